tile_sequencer: RTL and testbench
=================================

# tile_sequencer

Top-level controller for the tensor-core tile datapath. It latches one GEMM mode (`full_type_t`), then sequences the work for that mode:
- C/A/B loads through the AXI loader;
- the systolic pass;
- the INT accumulate phase;
- writeback.

It iterates over A row-tiles and B column-tiles until the whole M×N×K16 result is produced. It sits between the command interface and the loader, systolic array and writeback units.

## Interface
- `SYS_CYC_FP`, 32: SYSTOLIC duration in cycles for FP32/FP16.
- `SYS_CYC_INT`, 24: SYSTOLIC duration in cycles for INT8/INT4.
- `ACC_CYC`, 4: ACCUMULATE duration in cycles (INT only).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: job request, sampled only in IDLE.
- `mode` in 4: `full_type_t` code, latched with `start`.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse in FINISH.
- `err` out 1: one-cycle pulse when an illegal mode is rejected.
- `state` out 4: current `state_t` encoding.
- `ld_req` out 1: load request, held until `ld_done`.
- `ld_sel` out 2: `mat_t` being loaded (A=0, B=1, C=2).
- `ld_a_idx` out 2: current A row-tile index.
- `ld_b_idx` out 2: current B column-tile index.
- `ld_done` in 1: load-complete pulse from the loader.
- `sys_start` out 1: pulse in the first SYSTOLIC cycle.
- `acc_en` out 1: high throughout ACCUMULATE.
- `wb_req` out 1: writeback request, held until `wb_ack`.
- `wb_ack` in 1: writeback complete.
- `perf_cycles` out 32: present only with `TILE_SEQ_PERF_EN`.

## Operation
- **Mode decode** (from the latched mode):
  - dtype = mode/3 (FP32, FP16, INT8, INT4).
  - shape = mode%3.
  - counter_A (A tiles): m16n16 → 2, m8n32 → 1, m32n8 → 4.
  - counter_B (B tiles per A tile): m16n16 → 2, m8n32 → 4, m32n8 → 1.
  - need_accumulate = dtype is INT8 or INT4.
  - systolic length = `SYS_CYC_INT` for INT, else `SYS_CYC_FP`.
- **States:** IDLE, INIT_WAIT_C, INIT_WAIT_A, INIT_WAIT_B, SYSTOLIC, ACCUMULATE, WRITE_BACK, READ_C, WAIT_A, WAIT_B, FINISH. Encodings per `state_t`.
- **Transitions:**
  - IDLE + `start` + legal mode → INIT_WAIT_C.
  - IDLE + `start` + mode ≥ 12 → `err` pulse, stay IDLE.
  - INIT_WAIT_C → INIT_WAIT_A → INIT_WAIT_B, and READ_C → WAIT_A → WAIT_B: each advances on `ld_done`.
  - INIT_WAIT_B / WAIT_B → SYSTOLIC on `ld_done`.
  - SYSTOLIC lasts exactly its systolic length, then → ACCUMULATE if need_accumulate, else → WRITE_BACK.
  - ACCUMULATE lasts exactly `ACC_CYC` cycles, then → WRITE_BACK.
  - WRITE_BACK on `wb_ack`:
    - b_idx < counter_B−1 → increment b_idx, go to WAIT_B;
    - else a_idx < counter_A−1 → increment a_idx, clear b_idx, go to READ_C;
    - else → FINISH.
  - FINISH → IDLE after 1 cycle.
- **Load and writeback outputs:**
  - `ld_req` = 1 in every load state.
  - `ld_sel` = C in INIT_WAIT_C/READ_C, A in INIT_WAIT_A/WAIT_A, B in INIT_WAIT_B/WAIT_B; 0 elsewhere.
  - `wb_req` = 1 in WRITE_BACK.
- **Ignored inputs:**
  - `ld_done` outside load states.
  - `wb_ack` outside WRITE_BACK.
  - `start` while busy.
- A single duration counter is reused by SYSTOLIC and ACCUMULATE. It is cleared on every state entry.

## Timing
- All outputs are registered or decoded from the registered state (Moore). Input-to-output latency is 1 cycle.
- **Reset:** a `rst` high at a clock edge forces, from that edge:
  - `state` = IDLE;
  - every output = 0;
  - counters = 0;
  - latched mode = 0.
  - This applies mid-job too; no pending `done` is produced.
- **Job start:** `start` sampled at edge t0 → INIT_WAIT_C with `ld_req`=1 from t0+1.
- **Load handshake:** a load state entered at cycle t with `ld_done` already high in that same cycle (zero-delay loader) leaves at t+1, so the state is occupied for 1 cycle.
- **SYSTOLIC:** `sys_start` is high only in cycle 1 of SYSTOLIC.
- **Index outputs:** `ld_a_idx`/`ld_b_idx` are stable throughout every load state. They change only on WRITE_BACK exit.
- **Simultaneous `wb_ack` and `rst`:** reset wins.

## Configuration
- **`TILE_SEQ_PERF_EN`**
  - Defined: 32-bit `perf_cycles` increments on every cycle with `busy`=1, saturating at 0xFFFFFFFF. It clears on `rst` and on job acceptance, and holds its value in IDLE.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- **Zero-delay INT8_m8n32k16:** mode=7, `ld_done`/`wb_ack` tied high, `start` at t0.
  - Expect SYSTOLIC entries at t0+4, +34, +64, +94.
  - Expect 4 writebacks and `done` at t0+123.
  - Expect `ld_sel` sequence C, A, B, B, B, B.
- **FP32_m16n16k16:** mode=0.
  - Expect `ld_sel` order C, A, B, B, C, A, B, B.
  - Expect `ld_a_idx`/`ld_b_idx` to follow (0,0), (0,1), (1,0), (1,1).
  - Expect `acc_en` never asserted, each SYSTOLIC lasting 32 cycles, and 4 `wb_req` handshakes.
- **Stall handling:** `ld_done` delayed 5 cycles and `wb_ack` delayed 3 cycles (mode=2).
  - Expect `ld_req`/`wb_req` held steady with stable `ld_sel` and indices.
  - Expect no state advance before the response.
- **Illegal mode and ignored inputs:**
  - mode=13 with `start` → `err` pulse, `busy` stays 0.
  - `start` pulsed during SYSTOLIC → ignored.
  - stray `ld_done` during SYSTOLIC → no effect.
- **Reset mid-job:** `rst` asserted in ACCUMULATE (mode=9) → next cycle IDLE with all outputs 0. A fresh `start` then runs the job correctly from tile (0,0).
- **Perf counter:** with `TILE_SEQ_PERF_EN` defined, the first scenario yields `perf_cycles`=123 after `done`.

Source files
------------

// File: rtl/tile_sequencer.sv
// tile_sequencer: job controller for the tensor-core tile datapath.
// Latches one GEMM mode, then walks C/A/B loads, the systolic pass, the INT
// accumulate phase and writeback for every (A row-tile, B column-tile) pair.
// Optional macro TILE_SEQ_PERF_EN adds a saturating busy-cycle counter on
// port perf_cycles.
module tile_sequencer #(
    parameter int unsigned SYS_CYC_FP  = 32,
    parameter int unsigned SYS_CYC_INT = 24,
    parameter int unsigned ACC_CYC     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  mode,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  state,
    output logic        ld_req,
    output logic [1:0]  ld_sel,
    output logic [1:0]  ld_a_idx,
    output logic [1:0]  ld_b_idx,
    input  logic        ld_done,
    output logic        sys_start,
    output logic        acc_en,
    output logic        wb_req,
    input  logic        wb_ack
`ifdef TILE_SEQ_PERF_EN
    ,
    output logic [31:0] perf_cycles
`endif
);

    localparam int unsigned CNT_W = 8;

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_INIT_WAIT_C = 4'd1;
    localparam logic [3:0] S_INIT_WAIT_A = 4'd2;
    localparam logic [3:0] S_INIT_WAIT_B = 4'd3;
    localparam logic [3:0] S_SYSTOLIC    = 4'd4;
    localparam logic [3:0] S_ACCUMULATE  = 4'd5;
    localparam logic [3:0] S_WRITE_BACK  = 4'd6;
    localparam logic [3:0] S_READ_C      = 4'd7;
    localparam logic [3:0] S_WAIT_A      = 4'd8;
    localparam logic [3:0] S_WAIT_B      = 4'd9;
    localparam logic [3:0] S_FINISH      = 4'd10;

    localparam logic [1:0] MAT_A = 2'd0;
    localparam logic [1:0] MAT_B = 2'd1;
    localparam logic [1:0] MAT_C = 2'd2;

    logic [3:0]       state_q, state_d;
    logic [3:0]       mode_q, mode_d;
    logic [1:0]       a_idx_q, a_idx_d;
    logic [1:0]       b_idx_q, b_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ld_req_q, ld_req_d;
    logic [1:0]       ld_sel_q, ld_sel_d;
    logic             sys_start_q, sys_start_d;
    logic             acc_en_q, acc_en_d;
    logic             wb_req_q, wb_req_d;

    logic [1:0]       shape;
    logic [1:0]       last_a;
    logic [1:0]       last_b;
    logic             need_acc;
    logic [CNT_W-1:0] sys_last;
    logic [CNT_W-1:0] acc_last;
    logic             accept;

    // Decode tile counts and phase lengths from the latched mode
    always_comb begin
        shape    = 2'(mode_q % 4'd3);
        need_acc = (mode_q >= 4'd6);
        last_a   = 2'd1;
        last_b   = 2'd1;
        case (shape)
            2'd0:    begin last_a = 2'd1; last_b = 2'd1; end
            2'd1:    begin last_a = 2'd0; last_b = 2'd3; end
            default: begin last_a = 2'd3; last_b = 2'd0; end
        endcase
        sys_last = need_acc ? CNT_W'(SYS_CYC_INT - 1) : CNT_W'(SYS_CYC_FP - 1);
        acc_last = CNT_W'(ACC_CYC - 1);
    end

    // Next state, tile indices, duration counter and registered output values
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        a_idx_d     = a_idx_q;
        b_idx_d     = b_idx_q;
        err_d       = 1'b0;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mode < 4'd12) begin
                        accept  = 1'b1;
                        mode_d  = mode;
                        a_idx_d = 2'd0;
                        b_idx_d = 2'd0;
                        state_d = S_INIT_WAIT_C;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_INIT_WAIT_C: if (ld_done) state_d = S_INIT_WAIT_A;
            S_INIT_WAIT_A: if (ld_done) state_d = S_INIT_WAIT_B;
            S_INIT_WAIT_B: if (ld_done) state_d = S_SYSTOLIC;
            S_READ_C:      if (ld_done) state_d = S_WAIT_A;
            S_WAIT_A:      if (ld_done) state_d = S_WAIT_B;
            S_WAIT_B:      if (ld_done) state_d = S_SYSTOLIC;
            S_SYSTOLIC: begin
                if (cnt_q == sys_last) state_d = need_acc ? S_ACCUMULATE : S_WRITE_BACK;
            end
            S_ACCUMULATE: begin
                if (cnt_q == acc_last) state_d = S_WRITE_BACK;
            end
            S_WRITE_BACK: begin
                if (wb_ack) begin
                    if (b_idx_q < last_b) begin
                        b_idx_d = b_idx_q + 2'd1;
                        state_d = S_WAIT_B;
                    end else if (a_idx_q < last_a) begin
                        a_idx_d = a_idx_q + 2'd1;
                        b_idx_d = 2'd0;
                        state_d = S_READ_C;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Restart on every state change; only the timed states count
        if (state_d != state_q || !(state_q == S_SYSTOLIC || state_q == S_ACCUMULATE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FINISH);
        ld_req_d    = (state_d == S_INIT_WAIT_C) || (state_d == S_INIT_WAIT_A) ||
                      (state_d == S_INIT_WAIT_B) || (state_d == S_READ_C) ||
                      (state_d == S_WAIT_A)      || (state_d == S_WAIT_B);
        sys_start_d = (state_d == S_SYSTOLIC) && (state_q != S_SYSTOLIC);
        acc_en_d    = (state_d == S_ACCUMULATE);
        wb_req_d    = (state_d == S_WRITE_BACK);
        ld_sel_d    = 2'd0;
        case (state_d)
            S_INIT_WAIT_C, S_READ_C: ld_sel_d = MAT_C;
            S_INIT_WAIT_A, S_WAIT_A: ld_sel_d = MAT_A;
            S_INIT_WAIT_B, S_WAIT_B: ld_sel_d = MAT_B;
            default:                 ld_sel_d = 2'd0;
        endcase
    end

    // State, context and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 4'd0;
            a_idx_q     <= 2'd0;
            b_idx_q     <= 2'd0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ld_req_q    <= 1'b0;
            ld_sel_q    <= 2'd0;
            sys_start_q <= 1'b0;
            acc_en_q    <= 1'b0;
            wb_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            a_idx_q     <= a_idx_d;
            b_idx_q     <= b_idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ld_req_q    <= ld_req_d;
            ld_sel_q    <= ld_sel_d;
            sys_start_q <= sys_start_d;
            acc_en_q    <= acc_en_d;
            wb_req_q    <= wb_req_d;
        end
    end

    assign state     = state_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ld_req    = ld_req_q;
    assign ld_sel    = ld_sel_q;
    assign ld_a_idx  = a_idx_q;
    assign ld_b_idx  = b_idx_q;
    assign sys_start = sys_start_q;
    assign acc_en    = acc_en_q;
    assign wb_req    = wb_req_q;

`ifdef TILE_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: cleared on job acceptance, saturating, held in IDLE
    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = 32'd0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register
    always_ff @(posedge clk) begin
        if (rst) perf_q <= 32'd0;
        else     perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: expected handshake/phase events are
// queued before each job and a negedge monitor pops and compares them.
module tb_tile_sequencer;

    localparam int K_LD   = 0;
    localparam int K_SYS  = 1;
    localparam int K_ACC  = 2;
    localparam int K_WB   = 3;
    localparam int K_DONE = 4;
    localparam int K_ERR  = 5;
    localparam int LD_DLY = 5;
    localparam int WB_DLY = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  mode;
    logic        busy, done, err;
    logic [3:0]  state;
    logic        ld_req;
    logic [1:0]  ld_sel, ld_a_idx, ld_b_idx;
    logic        ld_done;
    logic        sys_start, acc_en, wb_req;
    logic        wb_ack;
`ifdef TILE_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int t0     = 0;

    logic ld_tie   = 1'b1;
    logic wb_tie   = 1'b1;
    logic ld_stray = 1'b0;

    tile_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state      (state),
        .ld_req     (ld_req),
        .ld_sel     (ld_sel),
        .ld_a_idx   (ld_a_idx),
        .ld_b_idx   (ld_b_idx),
        .ld_done    (ld_done),
        .sys_start  (sys_start),
        .acc_en     (acc_en),
        .wb_req     (wb_req),
        .wb_ack     (wb_ack)
`ifdef TILE_SEQ_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, offset %0d)", name, act, expv, cyc, cyc - t0);
        end
    endtask

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Load event value: sel*16 + a*4 + b
    function automatic int ldv(input int sel, input int a, input int b);
        return 16 * sel + 4 * a + b;
    endfunction

    // Loader and writeback responders: tied high, or delayed handshakes
    initial begin : resp
        int lc;
        int wc;
        lc = 0;
        wc = 0;
        ld_done = 1'b0;
        wb_ack  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ld_tie) begin
                ld_done = 1'b1;
            end else if (ld_req && !ld_done) begin
                lc++;
                if (lc >= LD_DLY) begin
                    ld_done = 1'b1;
                    lc = 0;
                end
            end else begin
                ld_done = ld_stray;
                lc = 0;
            end
            if (wb_tie) begin
                wb_ack = 1'b1;
            end else if (wb_req && !wb_ack) begin
                wc++;
                if (wc >= WB_DLY) begin
                    wb_ack = 1'b1;
                    wc = 0;
                end
            end else begin
                wb_ack = 1'b0;
                wc = 0;
            end
        end
    end

    logic       acc_prev = 1'b0;
    logic       pend_ld  = 1'b0;
    logic       pend_wb  = 1'b0;
    logic [3:0] prev_state;
    logic [1:0] prev_sel, prev_a, prev_b;

    // Monitor: pop and compare on every observed event, plus stall stability
    always @(negedge clk) begin : mon
        int  k;
        int  v;
        bit  hit;
        ev_t e;
        hit = 1'b1;
        k = 0;
        v = 0;
        if (ld_req && ld_done) begin
            k = K_LD;
            v = ldv(int'(ld_sel), int'(ld_a_idx), int'(ld_b_idx));
        end else if (sys_start) begin
            k = K_SYS;  v = cyc - t0;
        end else if (acc_en && !acc_prev) begin
            k = K_ACC;  v = cyc - t0;
        end else if (wb_req && wb_ack) begin
            k = K_WB;   v = 4 * int'(ld_a_idx) + int'(ld_b_idx);
        end else if (done) begin
            k = K_DONE; v = cyc - t0;
        end else if (err) begin
            k = K_ERR;  v = cyc - t0;
        end else begin
            hit = 1'b0;
        end
        acc_prev = acc_en;

        if (hit) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_event: got kind %0d val %0d, expected no event (offset %0d)", k, v, cyc - t0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", k, e.kind);
                if (e.val >= 0) check("event_val", v, e.val);
            end
        end

        if (pend_ld) begin
            check("stall_ld_req", int'(ld_req), 1);
            check("stall_ld_state", int'(state), int'(prev_state));
            check("stall_ld_sel", int'(ld_sel), int'(prev_sel));
            check("stall_ld_idx", 4 * int'(ld_a_idx) + int'(ld_b_idx), 4 * int'(prev_a) + int'(prev_b));
        end
        if (pend_wb) begin
            check("stall_wb_req", int'(wb_req), 1);
            check("stall_wb_state", int'(state), int'(prev_state));
            check("stall_wb_idx", 4 * int'(ld_a_idx) + int'(ld_b_idx), 4 * int'(prev_a) + int'(prev_b));
        end
        pend_ld    = ld_req && !ld_done && !rst;
        pend_wb    = wb_req && !wb_ack && !rst;
        prev_state = state;
        prev_sel   = ld_sel;
        prev_a     = ld_a_idx;
        prev_b     = ld_b_idx;
    end

    task automatic start_job(input logic [3:0] m);
        @(posedge clk);
        #1;
        mode  = m;
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout: %0d expected events still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_sys(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sys_start && n < budget);
        if (!sys_start) begin
            n_vec++;
            n_miss++;
            $display("FAIL sys_wait_timeout: sys_start got 0, expected 1 within %0d cycles", budget);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_ld_req"}, int'(ld_req), 0);
        check({tag, "_ld_sel"}, int'(ld_sel), 0);
        check({tag, "_idx"}, 4 * int'(ld_a_idx) + int'(ld_b_idx), 0);
        check({tag, "_sys_start"}, int'(sys_start), 0);
        check({tag, "_acc_en"}, int'(acc_en), 0);
        check({tag, "_wb_req"}, int'(wb_req), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Zero-delay INT8 m8n32: one A tile, four B tiles, with accumulate
        push(K_LD, ldv(2, 0, 0));
        push(K_LD, ldv(0, 0, 0));
        for (int b = 0; b < 4; b++) begin
            if (b > 0) push(K_LD, ldv(1, 0, b));
            else       push(K_LD, ldv(1, 0, 0));
            push(K_SYS, 4 + 30 * b);
            push(K_ACC, 28 + 30 * b);
            push(K_WB, b);
        end
        push(K_DONE, 123);
        start_job(4'd7);
        wait_sys(20);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 4'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_empty(400);
        @(negedge clk);
        check("post_job_busy", int'(busy), 0);
        check("post_job_state", int'(state), 0);
`ifdef TILE_SEQ_PERF_EN
        check("perf_cycles", int'(perf_cycles), 123);
        repeat (3) @(negedge clk);
        check("perf_hold", int'(perf_cycles), 123);
`endif

        // FP32 m16n16: 2x2 tiles, no accumulate, 32-cycle systolic
        push(K_LD, ldv(2, 0, 0)); push(K_LD, ldv(0, 0, 0)); push(K_LD, ldv(1, 0, 0));
        push(K_SYS, 4);   push(K_WB, 0);
        push(K_LD, ldv(1, 0, 1));
        push(K_SYS, 38);  push(K_WB, 1);
        push(K_LD, ldv(2, 1, 0)); push(K_LD, ldv(0, 1, 0)); push(K_LD, ldv(1, 1, 0));
        push(K_SYS, 74);  push(K_WB, 4);
        push(K_LD, ldv(1, 1, 1));
        push(K_SYS, 108); push(K_WB, 5);
        push(K_DONE, 141);
        start_job(4'd0);
        wait_empty(400);

        // Illegal mode: err pulse, stays idle
        push(K_ERR, 1);
        start_job(4'd13);
        @(negedge clk);
        check("illegal_busy", int'(busy), 0);
        check("illegal_state", int'(state), 0);
        wait_empty(10);

        // Stalled handshakes, FP32 m32n8: four A tiles, one B tile each
        ld_tie = 1'b0;
        wb_tie = 1'b0;
        repeat (2) @(posedge clk);
        for (int a = 0; a < 4; a++) begin
            push(K_LD, ldv(2, a, 0));
            push(K_LD, ldv(0, a, 0));
            push(K_LD, ldv(1, a, 0));
            push(K_SYS, -1);
            push(K_WB, 4 * a);
        end
        push(K_DONE, -1);
        start_job(4'd2);
        wait_sys(60);
        @(posedge clk);
        #1;
        ld_stray = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        ld_stray = 1'b0;
        @(negedge clk);
        check("stray_ld_state", int'(state), 4);
        wait_empty(2000);
        ld_tie = 1'b1;
        wb_tie = 1'b1;
        repeat (2) @(posedge clk);

        // Reset during ACCUMULATE (INT4 m16n16), then a clean rerun
        push(K_LD, ldv(2, 0, 0)); push(K_LD, ldv(0, 0, 0)); push(K_LD, ldv(1, 0, 0));
        push(K_SYS, 4); push(K_ACC, 28);
        start_job(4'd9);
        wait_empty(100);
        check("pre_reset_acc_en", int'(acc_en), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midjob_reset");
        repeat (4) @(negedge clk);
        check("post_reset_busy", int'(busy), 0);

        push(K_LD, ldv(2, 0, 0)); push(K_LD, ldv(0, 0, 0)); push(K_LD, ldv(1, 0, 0));
        push(K_SYS, 4);  push(K_ACC, 28);  push(K_WB, 0);
        push(K_LD, ldv(1, 0, 1));
        push(K_SYS, 34); push(K_ACC, 58);  push(K_WB, 1);
        push(K_LD, ldv(2, 1, 0)); push(K_LD, ldv(0, 1, 0)); push(K_LD, ldv(1, 1, 0));
        push(K_SYS, 66); push(K_ACC, 90);  push(K_WB, 4);
        push(K_LD, ldv(1, 1, 1));
        push(K_SYS, 96); push(K_ACC, 120); push(K_WB, 5);
        push(K_DONE, 125);
        start_job(4'd9);
        wait_empty(400);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
